// File: rtl/axis_seq_checker.sv
// axis_seq_checker: AXI-Stream sink checking an incrementing sequence under pseudo-random backpressure
module axis_seq_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [3:0]            throttle,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_err_data
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d, first_q, first_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic ready_q, ready_d;
  logic [CNT_WIDTH-1:0] rx_q, rx_d, err_q, err_d, rx_base, err_base;
  logic flag_q, flag_d, flag_base, acc, mis;
  always_comb begin
    acc       = s_tvalid && ready_q;
    mis       = acc && (s_tdata != exp_q);
    state_d   = enable ? RUN : IDLE;
    lfsr_d    = (state_q == RUN) ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    ready_d   = (state_d == RUN) && (lfsr_d[3:0] >= throttle);
    exp_d     = (state_q == IDLE && enable) ? seed : acc ? s_tdata + 1'b1 : exp_q;
    rx_base   = clear ? '0 : rx_q;
    err_base  = clear ? '0 : err_q;
    flag_base = clear ? 1'b0 : flag_q;
    rx_d      = (acc && ~&rx_base) ? rx_base + 1'b1 : rx_base;
    err_d     = (mis && ~&err_base) ? err_base + 1'b1 : err_base;
    flag_d    = flag_base | mis;
    first_d   = (mis && !flag_base) ? s_tdata : clear ? '0 : first_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      lfsr_q  <= 16'hACE1;
      ready_q <= 1'b0;
      rx_q    <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      first_q <= first_d;
    end
  end
  assign s_tready       = ready_q;
  assign rx_count       = rx_q;
  assign err_count      = err_q;
  assign err_flag       = flag_q;
  assign first_err_data = first_q;
endmodule

// File: tb/tb_axis_seq_checker.sv
// tb_axis_seq_checker: vector table, directed sequences and randomized run against a reference model
module tb_axis_seq_checker;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, clear = 1'b0, s_tvalid = 1'b0;
  logic [7:0] seed = '0, s_tdata = '0;
  logic [3:0] throttle = '0;
  logic s_tready, err_flag;
  logic [15:0] rx_count, err_count;
  logic [7:0] first_err_data;
  int n_chk = 0, n_fail = 0, n_rdy = 0;
  logic m_run, m_flag;
  logic [15:0] m_lfsr;
  logic [3:0] m_thr;
  logic [7:0] m_exp, m_first;
  int m_rx, m_err;

  typedef struct {
    logic en, clr, v;
    logic [7:0] d;
    logic rdy;
    int rx, err;
    logic flag;
  } vec_t;
  vec_t tbl[17];

  axis_seq_checker dut (
    .clk(clk), .rst(rst), .enable(enable), .seed(seed), .throttle(throttle), .clear(clear),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .rx_count(rx_count),
    .err_count(err_count), .err_flag(err_flag), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return m_run && (m_lfsr[3:0] >= m_thr);
  endfunction

  task automatic m_reset();
    m_run = 0; m_lfsr = 16'hACE1; m_thr = throttle; m_exp = 0;
    m_rx = 0; m_err = 0; m_flag = 0; m_first = 0;
  endtask

  task automatic m_edge(input logic e, c, v, input logic [7:0] d);
    logic acc;
    acc = v && m_ready();
    if (c) begin m_rx = 0; m_err = 0; m_flag = 0; m_first = 0; end
    if (acc) begin
      if (m_rx < 65535) m_rx++;
      if (d != m_exp) begin
        if (m_err < 65535) m_err++;
        if (!m_flag) m_first = d;
        m_flag = 1;
      end
      m_exp = d + 8'd1;
    end
    if (m_run) m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    if (!m_run && e) m_exp = seed;
    m_run = e;
    m_thr = throttle;
  endtask

  task automatic cycle(input logic e, c, v, input logic [7:0] d);
    enable = e; clear = c; s_tvalid = v; s_tdata = d;
    chk("s_tready", s_tready, m_ready());
    n_rdy += int'(s_tready);
    @(posedge clk);
    m_edge(e, c, v, d);
    #1;
    chk("rx_count", rx_count, m_rx);
    chk("err_count", err_count, m_err);
    chk("err_flag", err_flag, m_flag);
    chk("first_err_data", first_err_data, m_first);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, s_tready, 0);
    chk({tag, "_rx"}, rx_count, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_flag"}, err_flag, 0);
    chk({tag, "_first"}, first_err_data, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 0};
    for (int i = 1; i < 17; i++) tbl[i] = '{1, 0, 1, 8'(8'h0F + i), 1, i, 0, 0};
    m_reset();
    #12;
    chk_reset_outputs("reset");
    rst = 1;
    seed = 8'h10;
    for (int i = 0; i < 17; i++) begin
      chk("tbl_ready", s_tready, tbl[i].rdy);
      cycle(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].d);
      chk("tbl_rx", rx_count, tbl[i].rx);
      chk("tbl_err", err_count, tbl[i].err);
      chk("tbl_flag", err_flag, tbl[i].flag);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    seed = 8'hFE;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 8'hFE); cycle(1, 0, 1, 8'hFF); cycle(1, 0, 1, 8'h00); cycle(1, 0, 1, 8'h01);
    chk("wrap_rx", rx_count, 4);
    chk("wrap_err", err_count, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    seed = 8'h00;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 8'h00); cycle(1, 0, 1, 8'h01); cycle(1, 0, 1, 8'h02);
    cycle(1, 0, 1, 8'h05); cycle(1, 0, 1, 8'h06); cycle(1, 0, 1, 8'h07);
    chk("gap_rx", rx_count, 6);
    chk("gap_err", err_count, 1);
    chk("gap_first", first_err_data, 8'h05);
    cycle(1, 1, 1, 8'hAA);
    chk("clr_rx", rx_count, 1);
    chk("clr_err", err_count, 1);
    chk("clr_flag", err_flag, 1);
    chk("clr_first", first_err_data, 8'hAA);
    throttle = 4'd8;
    cycle(1, 0, 0, 0);
    n_rdy = 0;
    for (int i = 0; i < 4096; i++)
      cycle(1, i == 0, 1, ($urandom_range(0, 7) == 0) ? 8'($urandom) : m_exp);
    chk("rand_rx_vs_ready", rx_count, n_rdy);
    chk("rand_duty_ok", int'(n_rdy > 1600 && n_rdy < 2500), 1);
    throttle = 4'($urandom_range(0, 15));
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0) ? 8'($urandom) : m_exp);
    throttle = 4'd0;
    cycle(1, 0, 0, 0);
    @(posedge clk);
    #1 s_tvalid = 1; s_tdata = m_exp;
    #3 rst = 0;
    #1;
    chk_reset_outputs("midreset");
    m_reset();
    rst = 1;
    seed = 8'h40;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 8'h40);
    chk("post_rst_rx", rx_count, 1);
    chk("post_rst_err", err_count, 0);
    chk("post_rst_flag", err_flag, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
